// File: rtl/spike_window_classifier_pkg.sv
// Shared definitions for the spike window classifier: FSM encoding,
// default sizing and the counter saturation limit.
package spike_window_classifier_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_WIN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    function automatic int sat_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/spike_window_classifier_sat_counter.sv
// Saturating per-neuron spike counter; clear wins over inc, holds at all-ones.
module sat_spike_counter
    import spike_window_classifier_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spike_window_classifier.sv
// Integrates neuron spikes over a window of enabled cycles, then scans the
// counters one neuron per cycle to pick the most active neuron.
//
// state   | meaning
// IDLE    | waiting for start; previous result and counts remain visible
// COUNT   | integrating spikes on enabled cycles until the window expires
// COMPARE | scanning neuron counts 0..N-1, one per cycle
// HOLD    | result valid, waiting for result_ready
module spike_window_classifier
    import spike_window_classifier_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [N-1:0]       spikes_in,
    input  logic [WIN_W-1:0]   window_len,
    input  logic               start,
    output logic               busy,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [IDX_W-1:0]   winner,
    output logic [CNT_W-1:0]   winner_count,
    output logic               tie,
    output logic [N*CNT_W-1:0] spike_counts
);

    state_t           state;
    logic [WIN_W-1:0] remaining;
    logic [IDX_W-1:0] scan_idx;
    logic [CNT_W-1:0] counts [N];
    logic [CNT_W-1:0] scan_count;
    logic             accept;
    logic             count_en;

    assign accept     = (state == ST_IDLE) && start;
    assign count_en   = (state == ST_COUNT) && enable;
    assign scan_count = counts[scan_idx];

    for (genvar g = 0; g < N; g++) begin : g_cnt
        sat_spike_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (accept),
            .inc   (count_en && spikes_in[g]),
            .count (counts[g])
        );
        assign spike_counts[g*CNT_W +: CNT_W] = counts[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            scan_idx     <= '0;
            winner       <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_COUNT;
                        busy         <= 1'b1;
                        // A zero-length window still integrates one enabled cycle.
                        remaining    <= (window_len == '0) ? WIN_W'(1) : window_len;
                        scan_idx     <= '0;
                        winner       <= '0;
                        winner_count <= '0;
                        tie          <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (enable) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == WIN_W'(1)) begin
                            state <= ST_COMPARE;
                        end
                    end
                end
                ST_COMPARE: begin
                    // Strictly-greater replaces, so the lowest index keeps a tied win.
                    if (scan_count > winner_count) begin
                        winner       <= scan_idx;
                        winner_count <= scan_count;
                        tie          <= 1'b0;
                    end else if ((scan_count == winner_count) && (scan_count != '0)) begin
                        tie <= 1'b1;
                    end
                    if (scan_idx == IDX_W'(N - 1)) begin
                        state        <= ST_HOLD;
                        result_valid <= 1'b1;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (result_ready) begin
                        state        <= ST_IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_window_classifier.sv
// Scoreboard bench for spike_window_classifier: directed windows push expected
// results, a negedge monitor checks every HOLD cycle against them.
module tb_spike_window_classifier;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  spikes_in;
    logic [7:0]  window_len;
    logic        start;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [1:0]  winner;
    logic [3:0]  winner_count;
    logic        tie;
    logic [15:0] spike_counts;

    spike_window_classifier #(.N(4), .CNT_W(4), .WIN_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .spikes_in    (spikes_in),
        .window_len   (window_len),
        .start        (start),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .winner       (winner),
        .winner_count (winner_count),
        .tie          (tie),
        .spike_counts (spike_counts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  winner;
        logic [3:0]  wc;
        logic        tie;
        logic [15:0] counts;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_valid = 1'b0;

    logic [3:0] sp_tab [0:31];
    logic       en_tab [0:31];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    // Monitor: pop on the first HOLD cycle, re-check the same result every HOLD cycle.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (result_valid) begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result winner=%0d count=%0d", winner, winner_count);
                        cur = '{winner, winner_count, tie, spike_counts, 0, 0};
                    end else begin
                        cur = exp_q.pop_front();
                        chk("latency", cyc - cur.start_cyc, cur.lat);
                    end
                end
                chk("winner", winner, cur.winner);
                chk("winner_count", winner_count, cur.wc);
                chk("tie", tie, cur.tie);
                chk("spike_counts", spike_counts, cur.counts);
                chk("busy_in_hold", busy, 1);
            end
            prev_valid = result_valid;
        end
    end

    task automatic fill(input logic [3:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            sp_tab[i] = s;
            en_tab[i] = 1'b1;
        end
    endtask

    // Issues start, pushes the expected result, then plays ncount COUNT cycles.
    task automatic do_window(input logic [7:0] wl, input int ncount, input logic [1:0] w,
                             input logic [3:0] wc, input logic t, input logic [15:0] cnt,
                             input int lat);
        exp_t e;
        @(negedge clk);
        e = '{w, wc, t, cnt, lat, cyc};
        exp_q.push_back(e);
        start      = 1'b1;
        window_len = wl;
        spikes_in  = 4'b1111;
        enable     = 1'b1;
        for (int i = 0; i < ncount; i++) begin
            @(negedge clk);
            start     = 1'b0;
            spikes_in = sp_tab[i];
            enable    = en_tab[i];
        end
        @(negedge clk);
        start     = 1'b0;
        spikes_in = 4'b1111;
        enable    = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!result_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", result_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        spikes_in    = 4'b0;
        window_len   = 8'd0;
        start        = 1'b0;
        result_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_winner", winner, 0);
        chk("rst_winner_count", winner_count, 0);
        chk("rst_tie", tie, 0);
        chk("rst_counts", spike_counts, 0);

        // Single active neuron, W=5: 5+4+1 cycles.
        fill(4'b0100, 5);
        do_window(8'd5, 5, 2'd2, 4'd5, 1'b0, 16'h0500, 10);
        wait_idle();

        // Two-way tie, lowest index wins.
        fill(4'b1001, 3);
        do_window(8'd3, 3, 2'd0, 4'd3, 1'b1, 16'h3003, 8);
        wait_idle();

        // Saturation at 15 over a 20-cycle window.
        fill(4'b0010, 20);
        do_window(8'd20, 20, 2'd1, 4'd15, 1'b0, 16'h00F0, 25);
        wait_idle();

        // Enable toggling: disabled cycles carry all-ones spikes that must not count.
        for (int i = 0; i < 8; i++) begin
            en_tab[i] = i[0];
            sp_tab[i] = 4'b1111;
        end
        sp_tab[1] = 4'b0001;
        sp_tab[3] = 4'b0011;
        sp_tab[5] = 4'b0010;
        sp_tab[7] = 4'b0110;
        do_window(8'd4, 8, 2'd1, 4'd3, 1'b0, 16'h0132, 13);
        wait_idle();

        // Greater count after a tie clears the tie.
        sp_tab[0] = 4'b0111; en_tab[0] = 1'b1;
        sp_tab[1] = 4'b0100; en_tab[1] = 1'b1;
        do_window(8'd2, 2, 2'd2, 4'd2, 1'b0, 16'h0211, 7);
        wait_idle();

        // Zero window length behaves as one cycle; all-zero counts.
        fill(4'b0000, 1);
        do_window(8'd0, 1, 2'd0, 4'd0, 1'b0, 16'h0000, 6);
        wait_idle();

        // Reset in the second COUNT cycle discards the partial window.
        @(negedge clk);
        start      = 1'b1;
        window_len = 8'd5;
        spikes_in  = 4'b1111;
        enable     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("partial_counts_before_reset", spike_counts, 16'h1111);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_winner", winner, 0);
        chk("midrst_winner_count", winner_count, 0);
        chk("midrst_tie", tie, 0);
        chk("midrst_counts", spike_counts, 0);
        fill(4'b0010, 2);
        do_window(8'd2, 2, 2'd1, 4'd2, 1'b0, 16'h0020, 7);
        wait_idle();

        // Back-pressure in HOLD with a start pulse that must be ignored.
        result_ready = 1'b0;
        fill(4'b1000, 1);
        do_window(8'd1, 1, 2'd3, 4'd1, 1'b0, 16'h1000, 6);
        wait_valid();
        for (int i = 0; i < 6; i++) begin
            start      = (i == 2);
            window_len = 8'd3;
            spikes_in  = 4'b0111;
            enable     = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        chk("hold_still_valid", result_valid, 1);
        result_ready = 1'b1;
        @(negedge clk);
        chk("post_ready_busy", busy, 0);
        chk("post_ready_valid", result_valid, 0);
        chk("idle_winner_stable", winner, 3);
        chk("idle_counts_stable", spike_counts, 16'h1000);
        repeat (3) @(negedge clk);
        chk("ignored_start_busy", busy, 0);
        chk("ignored_start_counts", spike_counts, 16'h1000);
        enable = 1'b0;

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_window_classifier.md
SPIKE_WINDOW_CLASSIFIER -- requirements
Module: spike_window_classifier

Interface
REQ-001 Parameter N, default 4: number of neuron spike lines consumed from the neuron layer's output_spikes.
REQ-002 Parameter CNT_W, default 4: width of each per-neuron spike counter.
REQ-003 Parameter WIN_W, default 8: width of the window-length input.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 enable  input  1: same enable that drives the neuron layer; qualifies counting and window timing.
REQ-007 spikes_in  input  N: output spike vector from the neuron layer, bit i = neuron i.
REQ-008 window_len  input  WIN_W: number of enabled cycles to integrate; sampled at start.
REQ-009 start  input  1: request a classification window; accepted only in IDLE.
REQ-010 busy  output  1: high in COUNT, COMPARE and HOLD.
REQ-011 result_valid  output  1: result fields valid; high only in HOLD.
REQ-012 result_ready  input  1: consumer acceptance of the result.
REQ-013 winner  output  max(1,$clog2(N)): index of the neuron with the highest count.
REQ-014 winner_count  output  CNT_W: count of the winning neuron.
REQ-015 tie  output  1: more than one neuron holds the winning count.
REQ-016 spike_counts  output  N*CNT_W: per-neuron counters, neuron i at [i*CNT_W +: CNT_W].

Function
REQ-017 FSM states: IDLE, COUNT, COMPARE, HOLD, with no other reachable states.
REQ-018 IDLE->COUNT when start=1; start does not depend on enable; on acceptance, clear all counters, winner and tie, and latch window_len (value 0 is latched as 1).
REQ-019 start in any state other than IDLE is ignored, with no effect.
REQ-020 In COUNT, on each cycle with enable=1, increment counter i for every spikes_in[i]=1 and decrement the window remaining count by 1.
REQ-021 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-022 In COUNT, cycles with enable=0 change neither the counters nor the window timer.
REQ-023 COUNT->COMPARE on the cycle in which the last enabled window cycle is counted.
REQ-024 COMPARE scans neurons 0..N-1, one per cycle, for N cycles, independent of enable.
REQ-025 COMPARE update rule: a strictly greater count replaces winner and clears tie; an equal nonzero count sets tie; the lowest index wins ties.
REQ-026 All counts zero gives winner=0, winner_count=0, tie=0.
REQ-027 COMPARE->HOLD after the Nth scan cycle; result_valid=1 from the first HOLD cycle.
REQ-028 HOLD->IDLE on a cycle with result_valid=1 and result_ready=1.
REQ-029 Result fields and spike_counts remain stable throughout HOLD and in IDLE until the next start.
REQ-030 Latency: with start at cycle t and enable held high, result_valid rises at cycle t+W+N+1, where W is the latched window length.
REQ-031 spikes_in is ignored outside COUNT.

Reset
REQ-032 reset=1 at any clock edge forces IDLE and sets all outputs to 0: busy, result_valid, winner, winner_count, tie and spike_counts.
REQ-033 reset takes priority over start and result_ready in the same cycle.
REQ-034 Reset mid-window discards the partial counts.

Structure
REQ-035 A shared package holds the FSM state encoding (2-bit), the default parameter values and the counter saturation-maximum function.
REQ-036 One sub-module, sat_spike_counter (CNT_W-bit saturating counter with clear and inc), is instantiated N times via generate.
REQ-037 The module contains no clock gating and no asynchronous logic.

Verification
REQ-038 Scenario: N=4, window_len=5, spikes_in=4'b0100 for all 5 cycles -> winner=2, winner_count=5, tie=0, valid at t+10.
REQ-039 Scenario: window_len=3, spikes_in=4'b1001 every cycle -> winner=0, winner_count=3, tie=1.
REQ-040 Scenario: CNT_W=4, window_len=20, neuron 1 always spiking -> count saturates at 15, winner=1.
REQ-041 Scenario: window_len=4, enable toggled 1,0,1,0,... -> COUNT lasts 8 cycles and only enabled cycles are counted.
REQ-042 Scenario: reset pulsed during cycle 2 of COUNT -> next cycle is IDLE with all outputs 0, and a subsequent start works normally.
REQ-043 Scenario: result_ready held 0 for 6 cycles in HOLD, with start pulsed meanwhile -> result stable and start ignored; result_ready=1 -> IDLE on the next cycle.
